// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32I(+M) decode/control block.
//   - alu_op_e     : ALU operation encoding driven onto ALUControl
//   - OP_*         : major opcode values (instr[6:0])
//   - F7_*         : funct7 values that select base / alternate / M-extension
//   - RES_*, IMM_* : ResultSrc and ImmSrc codes
//   - ST_*         : control FSM state codes
//   - ctrl_t       : registered control bundle
//   - base_alu_op  : funct3 (+alternate bit) -> ALU op for R-type and I-ALU
package ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE     = 1'b0;
    localparam state_t ST_DIV_BUSY = 1'b1;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       mul_div;
        logic       illegal;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        alu_op_e    alu_op;
    } ctrl_t;

    // alt selects SUB over ADD (funct3 000) and SRA over SRL (funct3 101).
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_decode_comb.sv
// control_decode_comb: purely combinational RV32I(+M) instruction decoder.
//   instr  in  32      raw instruction word
//   ctrl   out ctrl_t  decoded control bundle (Illegal-only bundle for bad encodings)
//   is_div out 1       legal DIV/DIVU/REM/REMU, starts the divider busy window
module control_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit EN_M_EXT = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        is_div
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    ctrl_t      dec;
    logic       dec_div;
    logic       unused_fields;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    // Register/immediate fields are not needed for control decode.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec     = '0;
        dec_div = 1'b0;
        legal   = 1'b1;
        case (op)
            OP_R: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = base_alu_op(f3, f7[5]);
                end else if (f7 == F7_MEXT && EN_M_EXT) begin
                    // MUL..REMU are consecutive encodings indexed by funct3.
                    dec.reg_write = 1'b1;
                    dec.mul_div   = 1'b1;
                    dec.alu_op    = alu_op_e'(5'(ALU_MUL) + 5'(f3));
                    dec_div       = f3[2];
                end else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_I;
                // funct7 is only an opcode extension for shifts; otherwise it is immediate.
                dec.alu_op    = base_alu_op(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001)
                    legal = (f7 == F7_BASE);
                else if (f3 == 3'b101)
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                dec.imm_src    = IMM_I;
                dec.alu_op     = ALU_ADD;
                legal          = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm_src   = IMM_S;
                dec.alu_op    = ALU_ADD;
                legal         = !f3[2] && (f3 != 3'b011);
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_src = IMM_B;
                if (!f3[2])
                    dec.alu_op = ALU_SUB;
                else if (!f3[1])
                    dec.alu_op = ALU_SLT;
                else
                    dec.alu_op = ALU_SLTU;
                legal = (f3[2:1] != 2'b01);
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                dec.imm_src    = IMM_J;
                dec.alu_op     = ALU_ADD;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                dec.imm_src    = IMM_I;
                dec.alu_op     = ALU_ADD;
                legal          = (f3 == 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_op    = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_op    = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase

        // An illegal instruction still flows down the pipe, but with no side effects.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_div     = 1'b0;
        end
    end

    assign ctrl   = dec;
    assign is_div = dec_div;

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: decode stage registering the control bundle into ID/EX,
// with stall, flush and a divider structural-hazard FSM.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake from IF/ID
//   instr               raw instruction word
//   stall_ex            downstream stall, output register holds
//   flush               kills registered instruction and pending divide
//   out_valid + controls registered control bundle (RegWrite .. ALUControl)
//   fsm_state           current FSM state (ST_IDLE / ST_DIV_BUSY) for observation
//
// Handshake: an instruction transfers on a cycle where in_valid && in_ready and
// flush is low. in_ready is high only when out of reset, stall_ex is low and the
// FSM is IDLE; it never depends on in_valid. The producer must hold instr stable
// while in_valid is high and in_ready is low.
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 5,
    parameter bit EN_M_EXT    = 1'b1,
    parameter int DIV_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic                 stall_ex,
    input  logic                 flush,
    output logic                 out_valid,
    output logic                 RegWrite,
    output logic                 ALUSrc,
    output logic                 MemWrite,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 MulDiv,
    output logic                 Illegal,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [0:0]           fsm_state
);

    localparam int               CNT_W    = $clog2(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    ctrl_t            dec;
    logic             dec_div;
    ctrl_t            ctrl_q;
    logic             valid_q;
    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic             accept;

    control_decode_comb #(
        .EN_M_EXT (EN_M_EXT)
    ) u_decode (
        .instr  (instr),
        .ctrl   (dec),
        .is_div (dec_div)
    );

    assign in_ready = !rst && !stall_ex && (state == ST_IDLE);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            state   <= ST_IDLE;
            div_cnt <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            state   <= ST_IDLE;
            div_cnt <= '0;
        end else begin
            // Output register: load on accept, bubble when idle, hold on stall.
            if (!stall_ex) begin
                if (accept) begin
                    valid_q <= 1'b1;
                    ctrl_q  <= dec;
                end else begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                end
            end

            // Divider occupancy: DIV_LATENCY non-stalled cycles with in_ready low.
            case (state)
                ST_IDLE: begin
                    if (accept && dec_div) begin
                        state   <= ST_DIV_BUSY;
                        div_cnt <= CNT_LOAD;
                    end
                end
                default: begin
                    if (!stall_ex) begin
                        if (div_cnt == '0)
                            state <= ST_IDLE;
                        else
                            div_cnt <= div_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUSrc     = ctrl_q.alu_src;
    assign MemWrite   = ctrl_q.mem_write;
    assign Branch     = ctrl_q.branch;
    assign Jump       = ctrl_q.jump;
    assign MulDiv     = ctrl_q.mul_div;
    assign Illegal    = ctrl_q.illegal;
    assign ResultSrc  = ctrl_q.result_src;
    assign ImmSrc     = ctrl_q.imm_src;
    assign ALUControl = ALUCTRL_W'(ctrl_q.alu_op);
    assign fsm_state  = state;

endmodule
